// File: rtl/pedal_pkg.sv
// Shared types and defaults for the pedal chain sequencer.
// Imported by the sequencer top and its watchdog.
package pedal_pkg;

  localparam int N_STAGES_DEF = 4;
  localparam int W_DEF        = 16;
  localparam int TIMEOUT_DEF  = 255;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WAIT,
    DRAIN
  } seq_state_t;

  typedef logic [15:0] sample_t;

endpackage

// File: rtl/pedal_chain_sequencer_watchdog.sv
// Saturating cycle counter guarding one handshake phase.
// Cleared on phase entry, counts while enabled, flags expiry.
module stage_watchdog
  import pedal_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] count;

  // Count up while enabled; hold at all-ones instead of wrapping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != '1) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pedal_chain_sequencer.sv
// Runs one frame through the enabled pedals in order using
// each pedal's 4-phase START/DONE handshake on a shared bus.
module pedal_chain_sequencer
  import pedal_pkg::*;
#(
  parameter int N_STAGES = N_STAGES_DEF,
  parameter int W        = W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [W-1:0]          Sample_in,
  input  logic                  Sample_valid,
  input  logic [N_STAGES-1:0]   Enable,
  input  logic                  Clear_flags,
  output logic [N_STAGES-1:0]   Stage_start,
  output logic [W-1:0]          Stage_in,
  input  logic [N_STAGES-1:0]   Stage_done,
  input  logic [N_STAGES*W-1:0] Stage_out,
  output logic [W-1:0]          Signal_out,
  output logic                  Out_valid,
  output logic                  Busy,
  output logic                  Overrun,
  output logic [N_STAGES-1:0]   Timeout_err
);

  localparam int IW = $clog2(N_STAGES + 1);

  seq_state_t state, state_d;

  logic [W-1:0]        acc, acc_d;
  logic [IW-1:0]       idx, idx_d;
  logic [N_STAGES-1:0] en, en_d;
  logic [W-1:0]        sig_d;
  logic                ov_d;
  logic [N_STAGES-1:0] start_d;
  logic                busy_d;
  logic                ovr_d;
  logic [N_STAGES-1:0] terr_d;
  logic [N_STAGES-1:0] to_set;

  logic [N_STAGES-1:0] cur_oh;
  logic                cur_en;
  logic                cur_done;
  logic [W-1:0]        cur_out;

  logic wd_clr;
  logic wd_en;
  logic wd_exp;

  stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (wd_clr),
    .enable  (wd_en),
    .expired (wd_exp)
  );

  assign Stage_in = acc;

  // Decode the active stage; one-hot is zero once idx passes the end.
  always_comb begin
    cur_oh   = N_STAGES'(1) << idx;
    cur_en   = |(en & cur_oh);
    cur_done = |(Stage_done & cur_oh);
    cur_out  = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (idx == IW'(i)) begin
        cur_out = Stage_out[i*W +: W];
      end
    end
  end

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    idx_d   = idx;
    en_d    = en;
    sig_d   = Signal_out;
    ov_d    = 1'b0;
    start_d = Stage_start;
    to_set  = '0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;

    unique case (state)
      IDLE: begin
        if (Sample_valid) begin
          acc_d   = Sample_in;
          en_d    = Enable;
          idx_d   = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        wd_clr = 1'b1;
        if (idx == IW'(N_STAGES)) begin
          sig_d   = acc;
          ov_d    = 1'b1;
          state_d = IDLE;
        end else if (cur_en) begin
          start_d = cur_oh;
          state_d = WAIT;
        end else begin
          idx_d = idx + IW'(1);
        end
      end
      WAIT: begin
        if (cur_done) begin
          acc_d   = cur_out;
          start_d = '0;
          wd_clr  = 1'b1;
          state_d = DRAIN;
        end else if (wd_exp) begin
          start_d = '0;
          to_set  = cur_oh;
          wd_clr  = 1'b1;
          state_d = DRAIN;
        end else begin
          wd_en = 1'b1;
        end
      end
      DRAIN: begin
        if (!cur_done) begin
          idx_d   = idx + IW'(1);
          state_d = SELECT;
        end else if (wd_exp) begin
          to_set  = cur_oh;
          idx_d   = idx + IW'(1);
          state_d = SELECT;
        end else begin
          wd_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    if (Sample_valid && state != IDLE) begin
      ovr_d = 1'b1;
    end else if (Clear_flags) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = Overrun;
    end

    terr_d = (Timeout_err & ~{N_STAGES{Clear_flags}}) | to_set;
  end

  // Register state, datapath and every output.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      acc         <= '0;
      idx         <= '0;
      en          <= '0;
      Signal_out  <= '0;
      Out_valid   <= 1'b0;
      Stage_start <= '0;
      Busy        <= 1'b0;
      Overrun     <= 1'b0;
      Timeout_err <= '0;
    end else begin
      state       <= state_d;
      acc         <= acc_d;
      idx         <= idx_d;
      en          <= en_d;
      Signal_out  <= sig_d;
      Out_valid   <= ov_d;
      Stage_start <= start_d;
      Busy        <= busy_d;
      Overrun     <= ovr_d;
      Timeout_err <= terr_d;
    end
  end

endmodule
